// File: rtl/upsample2x.sv
// Streaming 2x2 nearest-neighbour upsampler: every input pixel is emitted twice per row,
// and each row is replayed from a line buffer to double it vertically.
module upsample2x #(
    parameter int DATA_W = 32,
    parameter int IN_W0  = 12,
    parameter int IN_W1  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     state,
    input  logic                     ivalid,
    output logic                     iready,
    input  logic signed [DATA_W-1:0] din,
    output logic                     ovalid,
    input  logic                     oready,
    output logic signed [DATA_W-1:0] dout,
    output logic                     oeol,
    output logic                     oeof
);

    localparam int CW = $clog2(IN_W0 + 1);

    typedef enum logic {FILL = 1'b0, REPLAY = 1'b1} phase_t;

    phase_t                    phase_q, phase_d;
    logic [CW-1:0]             col_q, col_d;
    logic [CW-1:0]             rcol_q, rcol_d;
    logic [CW-1:0]             row_q, row_d;
    logic [CW-1:0]             w_q, w_d;
    logic                      sub_q, sub_d;
    logic                      row_done_q, row_done_d;
    logic                      ovalid_q, ovalid_d;
    logic                      oeol_q, oeol_d;
    logic                      oeof_q, oeof_d;
    logic signed [DATA_W-1:0]  dout_q, dout_d;
    logic signed [DATA_W-1:0]  line_q [IN_W0];

    logic                      latch_w;
    logic [CW-1:0]             w_eff;
    logic [CW-1:0]             last;
    logic [CW-1:0]             rnext;
    logic                      itx;
    logic                      otx;

    // Width is only taken from the mode input while idle at frame start; the live value
    // is used in that same cycle so a first pixel arriving immediately sees the new width.
    assign latch_w = (phase_q == FILL) && (row_q == '0) && (col_q == '0) && !ovalid_q;
    assign w_eff   = latch_w ? (state ? CW'(IN_W1) : CW'(IN_W0)) : w_q;
    assign last    = w_eff - CW'(1);
    assign rnext   = rcol_q + CW'(1);

    assign iready = (phase_q == FILL) && !row_done_q && (!ovalid_q || (oready && sub_q));
    assign itx    = ivalid && iready;
    assign otx    = ovalid_q && oready;

    assign ovalid = ovalid_q;
    assign dout   = dout_q;
    assign oeol   = oeol_q;
    assign oeof   = oeof_q;

    always_comb begin
        phase_d    = phase_q;
        col_d      = col_q;
        rcol_d     = rcol_q;
        row_d      = row_q;
        w_d        = w_eff;
        sub_d      = sub_q;
        row_done_d = row_done_q;
        ovalid_d   = ovalid_q;
        oeol_d     = oeol_q;
        oeof_d     = oeof_q;
        dout_d     = dout_q;

        if (phase_q == FILL) begin
            if (itx) begin
                dout_d   = din;
                ovalid_d = 1'b1;
                sub_d    = 1'b0;
                oeol_d   = 1'b0;
                col_d    = col_q + CW'(1);
                if (col_q == last) begin
                    row_done_d = 1'b1;
                end
            end else if (otx) begin
                if (!sub_q) begin
                    sub_d  = 1'b1;
                    oeol_d = row_done_q;
                end else if (oeol_q) begin
                    phase_d    = REPLAY;
                    rcol_d     = '0;
                    sub_d      = 1'b0;
                    row_done_d = 1'b0;
                    oeol_d     = 1'b0;
                    ovalid_d   = 1'b1;
                    dout_d     = line_q[0];
                end else begin
                    ovalid_d = 1'b0;
                end
            end
        end else if (otx) begin
            if (!sub_q) begin
                sub_d = 1'b1;
                if (rcol_q == last) begin
                    oeol_d = 1'b1;
                    oeof_d = (row_q == last);
                end
            end else if (rcol_q == last) begin
                phase_d  = FILL;
                col_d    = '0;
                sub_d    = 1'b0;
                ovalid_d = 1'b0;
                oeol_d   = 1'b0;
                oeof_d   = 1'b0;
                row_d    = (row_q == last) ? '0 : row_q + CW'(1);
            end else begin
                rcol_d = rnext;
                sub_d  = 1'b0;
                dout_d = line_q[rnext];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q    <= FILL;
            col_q      <= '0;
            rcol_q     <= '0;
            row_q      <= '0;
            w_q        <= CW'(IN_W0);
            sub_q      <= 1'b0;
            row_done_q <= 1'b0;
            ovalid_q   <= 1'b0;
            oeol_q     <= 1'b0;
            oeof_q     <= 1'b0;
            dout_q     <= '0;
        end else begin
            phase_q    <= phase_d;
            col_q      <= col_d;
            rcol_q     <= rcol_d;
            row_q      <= row_d;
            w_q        <= w_d;
            sub_q      <= sub_d;
            row_done_q <= row_done_d;
            ovalid_q   <= ovalid_d;
            oeol_q     <= oeol_d;
            oeof_q     <= oeof_d;
            dout_q     <= dout_d;
        end
    end

    // Line buffer holds pixel data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (itx) begin
            line_q[col_q] <= din;
        end
    end

endmodule

// File: tb/tb_upsample2x.sv
// Directed bench for upsample2x: frame shapes, eol/eof marking, stalls, mode latching, reset.
module tb_upsample2x;

    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 state;
    logic                 ivalid;
    logic                 iready;
    logic signed [DW-1:0] din;
    logic                 ovalid;
    logic                 oready;
    logic signed [DW-1:0] dout;
    logic                 oeol;
    logic                 oeof;

    int n_cmp = 0;
    int n_err = 0;
    int in_px [144];
    int out_q [$];

    always #5 clk = ~clk;

    upsample2x #(.DATA_W(DW), .IN_W0(12), .IN_W1(4)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .state  (state),
        .ivalid (ivalid),
        .iready (iready),
        .din    (din),
        .ovalid (ovalid),
        .oready (oready),
        .dout   (dout),
        .oeol   (oeol),
        .oeof   (oeof)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one frame of w*w pixels from in_px and checks every output beat against
    // the nearest-neighbour model out[r][c] = in[r/2][c/2].
    task automatic run_frame(input int w, input bit rnd, input bit toggle, input bit gap_chk,
                             input string tag);
        int   n_in = 0, n_out = 0, n_eol = 0, n_eof = 0, cyc = 0;
        int   t_in = -1, t_ov = -1, ngap = 0, gap_run = 0, orow, ocol;
        bit   gap_on = 0, prev_stall = 0, toggled = 0;
        logic signed [DW-1:0] p_dout = '0;
        logic p_eol = 1'b0, p_eof = 1'b0;
        out_q.delete();
        while (n_out < 4*w*w && cyc < 20000) begin
            @(negedge clk);
            ivalid = (n_in < w*w) && (!rnd || $urandom_range(0, 3) != 0);
            din    = (n_in < w*w) ? DW'(in_px[n_in]) : '0;
            oready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (toggle && !toggled && n_in == 20) begin
                state   = ~state;
                toggled = 1;
            end
            #1;
            if (prev_stall) begin
                check({tag, "_stall_ovalid"}, 64'(ovalid), 64'(1));
                check({tag, "_stall_dout"}, 64'(dout), 64'(p_dout));
                check({tag, "_stall_eol"}, 64'(oeol), 64'(p_eol));
                check({tag, "_stall_eof"}, 64'(oeof), 64'(p_eof));
            end
            if (ovalid && t_ov < 0) t_ov = cyc;
            if (gap_on) begin
                if (!iready) gap_run++;
                else begin
                    check({tag, "_gap_len"}, 64'(gap_run), 64'(2*w));
                    ngap++;
                    gap_on = 0;
                end
            end
            if (ivalid && iready) begin
                if (t_in < 0) t_in = cyc;
                n_in++;
            end
            if (ovalid && oready) begin
                orow = n_out / (2*w);
                ocol = n_out % (2*w);
                check({tag, "_dout"}, 64'(dout), 64'(in_px[(orow/2)*w + ocol/2]));
                check({tag, "_oeol"}, 64'(oeol), 64'(ocol == 2*w-1));
                check({tag, "_oeof"}, 64'(oeof), 64'(n_out == 4*w*w-1));
                out_q.push_back(int'(dout));
                if (oeol) n_eol++;
                if (oeof) n_eof++;
                if (gap_chk && oeol && (orow % 2 == 0)) begin
                    gap_on  = 1;
                    gap_run = 0;
                end
                n_out++;
            end
            prev_stall = ovalid && !oready;
            p_dout = dout;
            p_eol  = oeol;
            p_eof  = oeof;
            cyc++;
        end
        check({tag, "_out_beats"}, 64'(n_out), 64'(4*w*w));
        check({tag, "_in_beats"}, 64'(n_in), 64'(w*w));
        check({tag, "_eol_count"}, 64'(n_eol), 64'(2*w));
        check({tag, "_eof_count"}, 64'(n_eof), 64'(1));
        check({tag, "_latency"}, 64'(t_ov - t_in), 64'(1));
        if (gap_chk) check({tag, "_gap_count"}, 64'(ngap), 64'(w-1));
        ivalid = 1'b0;
    endtask

    initial begin
        int acc;
        rstn   = 1'b0;
        state  = 1'b0;
        ivalid = 1'b0;
        oready = 1'b1;
        din    = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ovalid", 64'(ovalid), 64'(0));
        check("rst_dout", 64'(dout), 64'(0));
        check("rst_oeol", 64'(oeol), 64'(0));
        check("rst_oeof", 64'(oeof), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_iready", 64'(iready), 64'(1));

        // 4x4 ramp 1..16, hand-checked beats
        state = 1'b1;
        for (int i = 0; i < 16; i++) in_px[i] = i + 1;
        run_frame(4, 0, 0, 0, "ramp");
        if (out_q.size() == 64) begin
            check("ramp_b0", 64'(out_q[0]), 64'(1));
            check("ramp_b3", 64'(out_q[3]), 64'(2));
            check("ramp_b9", 64'(out_q[9]), 64'(1));
            check("ramp_b16", 64'(out_q[16]), 64'(5));
            check("ramp_b40", 64'(out_q[40]), 64'(9));
            check("ramp_b63", 64'(out_q[63]), 64'(16));
        end else begin
            check("ramp_size", 64'(out_q.size()), 64'(64));
        end

        // Back-pressure free, ivalid held: input stalls exactly one replayed row
        for (int i = 0; i < 16; i++) in_px[i] = -(i + 1);
        run_frame(4, 0, 0, 1, "gap");

        // 12x12 random signed data, random ready
        state = 1'b0;
        for (int i = 0; i < 144; i++) in_px[i] = int'($urandom);
        run_frame(12, 1, 0, 0, "rand12");

        // Mode toggled mid-frame is ignored; next frame uses the new mode
        for (int i = 0; i < 144; i++) in_px[i] = 1000 + i;
        run_frame(12, 0, 1, 0, "tog12");
        check("tog_state_now", 64'(state), 64'(1));
        for (int i = 0; i < 16; i++) in_px[i] = 2000 - i;
        run_frame(4, 0, 0, 0, "tog4");

        // Reset mid-row
        state = 1'b1;
        for (int i = 0; i < 16; i++) in_px[i] = 101 + i;
        acc = 0;
        for (int c = 0; c < 100 && acc < 3; c++) begin
            @(negedge clk);
            ivalid = 1'b1;
            oready = 1'b1;
            din    = DW'(in_px[acc]);
            #1;
            if (iready) acc++;
        end
        check("mid_accepted", 64'(acc), 64'(3));
        @(negedge clk);
        ivalid = 1'b0;
        #1;
        check("mid_ovalid_pre", 64'(ovalid), 64'(1));
        rstn = 1'b0;
        #1;
        check("mid_ovalid_rst", 64'(ovalid), 64'(0));
        check("mid_oeol_rst", 64'(oeol), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) in_px[i] = 201 + i;
        run_frame(4, 0, 0, 0, "post_rst");
        if (out_q.size() > 0) check("post_rst_first", 64'(out_q[0]), 64'(201));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
